// File: rtl/blink_iter_core.sv
// Round-iterative tweakable block cipher core with valid/ready handshakes on
// both sides, per-block encrypt/decrypt selection and UNROLL rounds per clock.
module blink_iter_core #(
  parameter int N      = 128,
  parameter int TW     = 256,
  parameter int ROUNDS = 20,
  parameter int R1     = 4,
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_enc,
  input  logic [N-1:0]          in_P,
  input  logic [TW-1:0]         in_T,
  input  logic [N*ROUNDS/2-1:0] K0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_C,
  output logic                  out_enc,
  output logic                  busy
);

  localparam int KW = N * ROUNDS / 2;
  localparam int TS = TW / N;
  localparam int CW = $clog2(ROUNDS);
  localparam logic [CW-1:0] ENC_LAST  = CW'(ROUNDS - UNROLL);
  localparam logic [CW-1:0] DEC_LAST  = CW'(UNROLL - 1);
  localparam logic [CW-1:0] DEC_FIRST = CW'(ROUNDS - 1);

  if (N < 8) begin : g_err_n
    $error("blink_iter_core: N must be at least 8");
  end
  if ((TW % N) != 0 || TW < N) begin : g_err_tw
    $error("blink_iter_core: TW must be a non-zero multiple of N");
  end
  if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_err_rounds
    $error("blink_iter_core: ROUNDS must be even and at least 2");
  end
  if (R1 <= 0 || R1 >= N) begin : g_err_r1
    $error("blink_iter_core: R1 must satisfy 0 < R1 < N");
  end
  if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_err_unroll
    $error("blink_iter_core: UNROLL must divide ROUNDS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] x);
    return (x << R1) | (x >> (N - R1));
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] x);
    return (x >> R1) | (x << (N - R1));
  endfunction

  // Round key: key slice idx/2 mixed with tweak slice idx mod (TW/N).
  function automatic logic [N-1:0] rkey(input logic [KW-1:0] k, input logic [TW-1:0] t,
                                        input int idx);
    return k[(idx / 2) * N +: N] ^ t[(idx % TS) * N +: N];
  endfunction

  function automatic logic [N-1:0] enc_round(input logic [N-1:0] s, input logic [N-1:0] rk,
                                             input int idx);
    return rotl((s ^ rk) + N'(idx));
  endfunction

  function automatic logic [N-1:0] dec_round(input logic [N-1:0] s, input logic [N-1:0] rk,
                                             input int idx);
    return (rotr(s) - N'(idx)) ^ rk;
  endfunction

  state_t          state_r, state_s;
  logic [N-1:0]    s_r, s_s;
  logic [TW-1:0]   t_r;
  logic            enc_r;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            last_s;
  logic            in_ready_s;
  logic            accept_s;
  logic [N-1:0]    out_c_r;
  logic            out_enc_r;
  logic            out_valid_r;
  logic            busy_r;

  // Unrolled round datapath and counter step for the current RUN cycle.
  always_comb begin
    s_s = s_r;
    for (int u = 0; u < UNROLL; u++) begin
      if (enc_r) begin
        s_s = enc_round(s_s, rkey(K0, t_r, int'(cnt_r) + u), int'(cnt_r) + u);
      end else begin
        s_s = dec_round(s_s, rkey(K0, t_r, int'(cnt_r) - u), int'(cnt_r) - u);
      end
    end
    if (enc_r) begin
      cnt_s  = cnt_r + CW'(UNROLL);
      last_s = (cnt_r == ENC_LAST);
    end else begin
      cnt_s  = cnt_r - CW'(UNROLL);
      last_s = (cnt_r == DEC_LAST);
    end
  end

  // Next-state and input-side handshake decode.
  always_comb begin
    state_s    = state_r;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = rst;
        if (in_valid && rst) state_s = RUN;
        else                 state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) begin
          // Output handshake and next accept share this cycle.
          in_ready_s = rst;
          if (in_valid) state_s = RUN;
          else          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign accept_s = in_ready_s & in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Block state, latched tweak/mode, round counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r         <= {N{1'b0}};
      t_r         <= {TW{1'b0}};
      enc_r       <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      out_c_r     <= {N{1'b0}};
      out_enc_r   <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        s_r   <= in_P;
        t_r   <= in_T;
        enc_r <= in_enc;
        cnt_r <= in_enc ? {CW{1'b0}} : DEC_FIRST;
      end else if (state_r == RUN) begin
        s_r   <= s_s;
        cnt_r <= cnt_s;
      end
      if (state_r == RUN && last_s) begin
        out_c_r   <= s_s;
        out_enc_r <= enc_r;
      end
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == RUN);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_C     = out_c_r;
  assign out_enc   = out_enc_r;
  assign busy      = busy_r;

endmodule
